pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 113 +++++++++++
 tb/tb_pipelined_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Segmented carry-pipelined adder/subtractor: one WIDTH/SEG-bit slice per stage,
// operand and sum slices skewed so each result leaves the last stage intact.
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int SEG   = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cg_en,
  input  logic             In_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             Sub,
  output logic             Out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SW = WIDTH / SEG;

  // Index 0 is the input register; index k (1..SEG) holds the result of stage k.
  logic             valid_q [0:SEG];
  logic             valid_d [0:SEG];
  logic             carry_q [0:SEG];
  logic             carry_d [0:SEG];
  logic [WIDTH-1:0] sum_q   [0:SEG];
  logic [WIDTH-1:0] sum_d   [0:SEG];
  logic [WIDTH-1:0] opa_q   [0:SEG-1];
  logic [WIDTH-1:0] opa_d   [0:SEG-1];
  logic [WIDTH-1:0] opb_q   [0:SEG-1];
  logic [WIDTH-1:0] opb_d   [0:SEG-1];
  logic             ovf_q;
  logic             ovf_d;

  always_comb begin
    valid_d[0] = In_valid;
    carry_d[0] = C;
    sum_d[0]   = '0;
    opa_d[0]   = A;
    opb_d[0]   = Sub ? ~B : B;
  end

  generate
    for (genvar gi = 1; gi <= SEG; gi++) begin : stage_g
      localparam logic [WIDTH-1:0] SLICE_MASK = {{(WIDTH-SW){1'b0}}, {SW{1'b1}}} << ((gi-1)*SW);
      logic [SW:0] slice_sum;

      always_comb begin
        slice_sum  = {1'b0, opa_q[gi-1][(gi-1)*SW +: SW]}
                   + {1'b0, opb_q[gi-1][(gi-1)*SW +: SW]}
                   + {{SW{1'b0}}, carry_q[gi-1]};
        valid_d[gi] = valid_q[gi-1];
        carry_d[gi] = slice_sum[SW];
        sum_d[gi]   = (sum_q[gi-1] & ~SLICE_MASK)
                    | ({{(WIDTH-SW){1'b0}}, slice_sum[SW-1:0]} << ((gi-1)*SW));
      end

      if (gi < SEG) begin : skew_g
        always_comb begin
          opa_d[gi] = opa_q[gi-1];
          opb_d[gi] = opb_q[gi-1];
        end
      end else begin : last_g
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        always_comb begin
          ovf_d = opa_q[gi-1][WIDTH-1] ^ opb_q[gi-1][WIDTH-1]
                ^ slice_sum[SW-1] ^ slice_sum[SW];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k <= SEG; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
      end
      for (int k = 0; k < SEG; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (cg_en) begin
      for (int k = 0; k <= SEG; k++) begin
        valid_q[k] <= valid_d[k];
        // Data only moves with a valid operation, so bubbles leave results in place.
        if (valid_d[k]) begin
          carry_q[k] <= carry_d[k];
          sum_q[k]   <= sum_d[k];
        end
      end
      for (int k = 0; k < SEG; k++) begin
        if (valid_d[k]) begin
          opa_q[k] <= opa_d[k];
          opb_q[k] <= opb_d[k];
        end
      end
      if (valid_d[SEG]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign Out_valid = valid_q[SEG];
  assign Sum       = sum_q[SEG];
  assign Carry     = carry_q[SEG];
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 8-bit/2-segment main instance plus
// 16-bit instances with one and four segments for latency scaling.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        cg_en;

  logic        iv8;
  logic [7:0]  a8, b8;
  logic        c8, sub8;
  logic        ov8;
  logic [7:0]  sum8;
  logic        cy8, of8;

  logic        iv16;
  logic [15:0] a16, b16;
  logic        ov16_1, ov16_4;
  logic [15:0] sum16_1, sum16_4;
  logic        cy16_1, cy16_4, of16_1, of16_4;

  int checks = 0;
  int errors = 0;

  pipelined_adder #(.WIDTH(8), .SEG(2)) dut8 (
    .Clock(clk), .Reset(rst), .cg_en(cg_en), .In_valid(iv8),
    .A(a8), .B(b8), .C(c8), .Sub(sub8),
    .Out_valid(ov8), .Sum(sum8), .Carry(cy8), .Overflow(of8)
  );

  pipelined_adder #(.WIDTH(16), .SEG(1)) dut16_1 (
    .Clock(clk), .Reset(rst), .cg_en(cg_en), .In_valid(iv16),
    .A(a16), .B(b16), .C(1'b0), .Sub(1'b0),
    .Out_valid(ov16_1), .Sum(sum16_1), .Carry(cy16_1), .Overflow(of16_1)
  );

  pipelined_adder #(.WIDTH(16), .SEG(4)) dut16_4 (
    .Clock(clk), .Reset(rst), .cg_en(cg_en), .In_valid(iv16),
    .A(a16), .B(b16), .C(1'b0), .Sub(1'b0),
    .Out_valid(ov16_4), .Sum(sum16_4), .Carry(cy16_4), .Overflow(of16_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then walk it through the 2-stage pipe checking latency and result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic sub,
                        input logic [7:0] es, input logic ec, input logic ev);
    a8 = a; b8 = b; c8 = c; sub8 = sub; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    check({tag, ".valid_e0"}, 64'(ov8), 64'(0));
    tick();
    check({tag, ".valid_e1"}, 64'(ov8), 64'(0));
    tick();
    check({tag, ".valid_e2"}, 64'(ov8), 64'(1));
    check({tag, ".sum"}, 64'(sum8), 64'(es));
    check({tag, ".carry"}, 64'(cy8), 64'(ec));
    check({tag, ".ovf"}, 64'(of8), 64'(ev));
    $display("op %s A=%02h B=%02h C=%0d Sub=%0d -> Sum=%02h Carry=%0d Ovf=%0d",
             tag, a, b, c, sub, sum8, cy8, of8);
    tick();
    check({tag, ".valid_e3"}, 64'(ov8), 64'(0));
    check({tag, ".sum_hold"}, 64'(sum8), 64'(es));
  endtask

  initial begin
    rst = 1'b1; cg_en = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0;
    tick();
    check("reset.valid", 64'(ov8), 64'(0));
    check("reset.sum", 64'(sum8), 64'(0));
    check("reset.carry", 64'(cy8), 64'(0));
    check("reset.ovf", 64'(of8), 64'(0));
    rst = 1'b0;
    tick();

    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("add_aa_55_c", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Three back-to-back ops with a two-cycle stall once the first emerges.
    c8 = 1'b0; sub8 = 1'b0;
    a8 = 8'h01; b8 = 8'h02; iv8 = 1'b1; tick();
    a8 = 8'h10; b8 = 8'h20; tick();
    a8 = 8'hFF; b8 = 8'hFF; tick();
    iv8 = 1'b0;
    check("b2b.first_valid", 64'(ov8), 64'(1));
    check("b2b.first_sum", 64'(sum8), 64'(8'h03));
    cg_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall.valid", 64'(ov8), 64'(1));
      check("stall.sum", 64'(sum8), 64'(8'h03));
    end
    cg_en = 1'b1;
    tick();
    check("b2b.second_valid", 64'(ov8), 64'(1));
    check("b2b.second_sum", 64'(sum8), 64'(8'h30));
    check("b2b.second_carry", 64'(cy8), 64'(0));
    tick();
    check("b2b.third_valid", 64'(ov8), 64'(1));
    check("b2b.third_sum", 64'(sum8), 64'(8'hFE));
    check("b2b.third_carry", 64'(cy8), 64'(1));
    check("b2b.third_ovf", 64'(of8), 64'(0));
    $display("op b2b stream done Sum=%02h Carry=%0d", sum8, cy8);
    tick();
    check("b2b.drained_valid", 64'(ov8), 64'(0));

    // Reset with two ops in flight.
    a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1; tick();
    a8 = 8'h33; b8 = 8'h44; tick();
    iv8 = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_fly.valid", 64'(ov8), 64'(0));
    check("rst_fly.sum", 64'(sum8), 64'(0));
    check("rst_fly.carry", 64'(cy8), 64'(0));
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_fly.no_ghost", 64'(ov8), 64'(0));
    end
    $display("op reset-in-flight discarded");
    run_op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // Latency scaling: 16-bit with one segment vs four segments.
    a16 = 16'hFFFF; b16 = 16'h0001; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("w16s1.valid", 64'(ov16_1), 64'(i == 1));
      check("w16s4.valid", 64'(ov16_4), 64'(i == 4));
      if (i == 1) begin
        check("w16s1.sum", 64'(sum16_1), 64'(16'h0000));
        check("w16s1.carry", 64'(cy16_1), 64'(1));
      end
      if (i == 4) begin
        check("w16s4.sum", 64'(sum16_4), 64'(16'h0000));
        check("w16s4.carry", 64'(cy16_4), 64'(1));
        check("w16s4.ovf", 64'(of16_4), 64'(0));
      end
    end
    $display("op w16 FFFF+0001 seg1 Sum=%04h seg4 Sum=%04h", sum16_1, sum16_4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
